one_wire_tx_master: RTL and testbench

- 1-Wire bus master transmitter: the read-side consumer of one_wire_bram.
- On start: issues a 1-Wire reset pulse, checks for presence, then fetches byte_count bytes from the BRAM read port starting at start_address and serialises each byte LSB-first as 1-Wire write slots.
- Drives an open-drain pull-low enable; tristate buffer lives at top level.

---
 rtl/one_wire_tx_master.sv | 211 +++++++++++++++++++++
 tb/tb_one_wire_tx_master.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/one_wire_tx_master.sv
// 1-Wire bus master transmitter: reset/presence handshake, then streams bytes
// fetched from the BRAM read port onto the bus as LSB-first write slots.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | waiting for start
// RST_LOW    | bus pulled low for the reset pulse
// PRES_WAIT  | bus released, presence sampled, reset window completes
// FETCH      | read_en held until data_dv or timeout
// BIT_LOW    | slot low phase (short for 1, long for 0)
// BIT_REL    | slot released until the slot length has elapsed
// RECOVERY   | released recovery between slots
// DONE       | one-cycle done pulse, busy drops
module one_wire_tx_master #(
    parameter int T_RST_LOW     = 24000,
    parameter int T_PRES_SAMPLE = 3500,
    parameter int T_RST_TOTAL   = 24000,
    parameter int T_W1_LOW      = 300,
    parameter int T_W0_LOW      = 3000,
    parameter int T_SLOT        = 3500,
    parameter int T_REC         = 100,
    parameter int RD_TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] start_address,
    input  logic [5:0] byte_count,
    output logic       read_en,
    output logic [4:0] read_address,
    input  logic [7:0] data_in,
    input  logic       data_dv,
    input  logic       ow_in,
    output logic       ow_drive_low,
    output logic       busy,
    output logic       done,
    output logic       presence,
    output logic       error
);

    localparam int T_MAX_A = (T_RST_LOW > T_RST_TOTAL) ? T_RST_LOW : T_RST_TOTAL;
    localparam int T_MAX_B = (T_SLOT > RD_TIMEOUT) ? T_SLOT : RD_TIMEOUT;
    localparam int T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int T_MAX   = (T_MAX_C > T_REC) ? T_MAX_C : T_REC;
    localparam int TW      = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] ONE          = TW'(1);
    localparam logic [TW-1:0] RST_LOW_M1   = TW'(T_RST_LOW - 1);
    localparam logic [TW-1:0] RST_TOTAL_M1 = TW'(T_RST_TOTAL - 1);
    localparam logic [TW-1:0] PRES_AT      = TW'(T_RST_TOTAL - T_PRES_SAMPLE);
    localparam logic [TW-1:0] W1_LOW_M1    = TW'(T_W1_LOW - 1);
    localparam logic [TW-1:0] W0_LOW_M1    = TW'(T_W0_LOW - 1);
    localparam logic [TW-1:0] SLOT_M1      = TW'(T_SLOT - 1);
    localparam logic [TW-1:0] REC_M1       = TW'(T_REC - 1);
    localparam logic [TW-1:0] RD_TO_M1     = TW'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_LOW,
        S_PRES_WAIT,
        S_FETCH,
        S_BIT_LOW,
        S_BIT_REL,
        S_RECOVERY,
        S_DONE
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   slot_timer;
    logic [5:0]      bytes_left;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic [1:0]      ow_sync;
    logic            presence_now;

    // presence may be sampled on the very edge that closes the reset window
    assign presence_now = presence | ((timer == PRES_AT) & ~ow_sync[1]);

    function automatic logic [TW-1:0] low_time(input logic b);
        return b ? W1_LOW_M1 : W0_LOW_M1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            timer        <= '0;
            slot_timer   <= '0;
            bytes_left   <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            ow_sync      <= 2'b11;
            read_en      <= 1'b0;
            read_address <= '0;
            ow_drive_low <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            presence     <= 1'b0;
            error        <= 1'b0;
        end else begin
            ow_sync <= {ow_sync[0], ow_in};
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (byte_count == 6'd0) begin
                            done <= 1'b1;
                        end else begin
                            bytes_left   <= byte_count;
                            read_address <= start_address;
                            presence     <= 1'b0;
                            error        <= 1'b0;
                            busy         <= 1'b1;
                            ow_drive_low <= 1'b1;
                            timer        <= RST_LOW_M1;
                            state        <= S_RST_LOW;
                        end
                    end
                end
                S_RST_LOW: begin
                    if (timer == '0) begin
                        ow_drive_low <= 1'b0;
                        timer        <= RST_TOTAL_M1;
                        state        <= S_PRES_WAIT;
                    end else begin
                        timer <= timer - ONE;
                    end
                end
                S_PRES_WAIT: begin
                    presence <= presence_now;
                    if (timer == '0) begin
                        if (presence_now) begin
                            read_en <= 1'b1;
                            timer   <= RD_TO_M1;
                            state   <= S_FETCH;
                        end else begin
                            error <= 1'b1;
                            state <= S_DONE;
                        end
                    end else begin
                        timer <= timer - ONE;
                    end
                end
                S_FETCH: begin
                    if (data_dv) begin
                        shreg        <= data_in;
                        bit_idx      <= 3'd0;
                        read_en      <= 1'b0;
                        ow_drive_low <= 1'b1;
                        timer        <= low_time(data_in[0]);
                        slot_timer   <= SLOT_M1;
                        state        <= S_BIT_LOW;
                    end else if (timer == '0) begin
                        read_en <= 1'b0;
                        error   <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        timer <= timer - ONE;
                    end
                end
                S_BIT_LOW: begin
                    slot_timer <= slot_timer - ONE;
                    if (timer == '0) begin
                        ow_drive_low <= 1'b0;
                        state        <= S_BIT_REL;
                    end else begin
                        timer <= timer - ONE;
                    end
                end
                S_BIT_REL: begin
                    if (slot_timer == '0) begin
                        timer <= REC_M1;
                        state <= S_RECOVERY;
                    end else begin
                        slot_timer <= slot_timer - ONE;
                    end
                end
                S_RECOVERY: begin
                    if (timer != '0) begin
                        timer <= timer - ONE;
                    end else if (bit_idx != 3'd7) begin
                        shreg        <= {1'b0, shreg[7:1]};
                        bit_idx      <= bit_idx + 3'd1;
                        ow_drive_low <= 1'b1;
                        timer        <= low_time(shreg[1]);
                        slot_timer   <= SLOT_M1;
                        state        <= S_BIT_LOW;
                    end else begin
                        // address is 5 bits wide, so 31 rolls over to 0
                        bytes_left   <= bytes_left - 6'd1;
                        read_address <= read_address + 5'd1;
                        if (bytes_left != 6'd1) begin
                            read_en <= 1'b1;
                            timer   <= RD_TO_M1;
                            state   <= S_FETCH;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_one_wire_tx_master.sv
// Scoreboarded bench for one_wire_tx_master: BRAM model, presence-pulse slave,
// and monitors that pop expected pulse widths/gaps and read addresses.
module tb_one_wire_tx_master;

    localparam int T_RST_LOW     = 20;
    localparam int T_PRES_SAMPLE = 6;
    localparam int T_RST_TOTAL   = 20;
    localparam int T_W1_LOW      = 2;
    localparam int T_W0_LOW      = 8;
    localparam int T_SLOT        = 10;
    localparam int T_REC         = 2;
    localparam int RD_TIMEOUT    = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [4:0] start_address = '0;
    logic [5:0] byte_count = '0;
    logic       read_en;
    logic [4:0] read_address;
    logic [7:0] data_in = '0;
    logic       data_dv = 1'b0;
    logic       ow_in;
    logic       ow_drive_low, busy, done, presence, error;

    always #5 clk = ~clk;

    one_wire_tx_master #(
        .T_RST_LOW(T_RST_LOW), .T_PRES_SAMPLE(T_PRES_SAMPLE), .T_RST_TOTAL(T_RST_TOTAL),
        .T_W1_LOW(T_W1_LOW), .T_W0_LOW(T_W0_LOW), .T_SLOT(T_SLOT), .T_REC(T_REC),
        .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .start_address(start_address),
        .byte_count(byte_count), .read_en(read_en), .read_address(read_address),
        .data_in(data_in), .data_dv(data_dv), .ow_in(ow_in), .ow_drive_low(ow_drive_low),
        .busy(busy), .done(done), .presence(presence), .error(error)
    );

    int checks = 0;
    int failures = 0;

    typedef struct { int width; int gap; } pulse_t;
    pulse_t pulse_q[$];
    int     addr_q[$];

    // BRAM model
    logic [7:0] mem [32];
    int   bram_lat = 3;
    bit   bram_noresp = 0;
    bit   bram_busy = 0;
    int   lat_cnt = 0;
    logic [4:0] addr_l = '0;

    always @(posedge clk) begin
        data_dv <= 1'b0;
        if (reset) begin
            bram_busy <= 0;
        end else if (bram_busy) begin
            if (lat_cnt == 0) begin
                data_dv   <= 1'b1;
                data_in   <= mem[addr_l];
                bram_busy <= 0;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end else if (read_en && !data_dv && !bram_noresp) begin
            bram_busy <= 1;
            lat_cnt   <= bram_lat - 2;
            addr_l    <= read_address;
        end
    end

    // Slave: pulls the bus low a few cycles after a reset pulse is released
    bit slave_present = 1;
    int drv_run = 0;
    int rel_cnt = 0;
    logic slave_low;

    always @(posedge clk) begin
        if (ow_drive_low) begin
            drv_run <= drv_run + 1;
            rel_cnt <= 0;
        end else begin
            drv_run <= 0;
            if (drv_run >= T_RST_LOW) rel_cnt <= 1;
            else if (rel_cnt != 0 && rel_cnt < 30) rel_cnt <= rel_cnt + 1;
            else rel_cnt <= 0;
        end
    end
    assign slave_low = slave_present && (rel_cnt >= 3) && (rel_cnt <= 10);
    assign ow_in = !(ow_drive_low || slave_low);

    // Monitors, sampled on the falling edge
    bit mon_en = 0;
    bit prev_drv = 0;
    bit prev_re = 0;
    int low_cnt = 0;
    int gap_cnt = 0;
    int exp_gap = -1;
    int pulse_starts = 0;
    int re_run = 0;
    int last_re_run = 0;
    int rd_cnt = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (done) done_cnt++;
            if (ow_drive_low) begin
                if (!prev_drv) begin
                    pulse_starts++;
                    if (exp_gap >= 0) begin
                        checks++;
                        if (gap_cnt !== exp_gap) begin
                            failures++;
                            $display("FAIL slot_gap: got %0d cycles released, expected %0d", gap_cnt, exp_gap);
                        end
                    end
                    exp_gap = -1;
                    low_cnt = 1;
                end else begin
                    low_cnt++;
                end
            end else begin
                if (prev_drv) begin
                    checks++;
                    if (pulse_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_pulse: low width %0d, expected no pulse", low_cnt);
                    end else begin
                        pulse_t p;
                        p = pulse_q.pop_front();
                        if (low_cnt !== p.width) begin
                            failures++;
                            $display("FAIL pulse_width: got %0d, expected %0d", low_cnt, p.width);
                        end
                        exp_gap = p.gap;
                    end
                    gap_cnt = 1;
                end else begin
                    gap_cnt++;
                end
            end
            prev_drv = ow_drive_low;

            if (read_en) begin
                if (!prev_re) begin
                    rd_cnt++;
                    checks++;
                    if (addr_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_read: address %0d, expected no read", read_address);
                    end else begin
                        int a;
                        a = addr_q.pop_front();
                        if (int'(read_address) !== a) begin
                            failures++;
                            $display("FAIL read_address: got %0d, expected %0d", read_address, a);
                        end
                    end
                end
                re_run++;
            end else if (prev_re) begin
                last_re_run = re_run;
                re_run = 0;
            end
            prev_re = read_en;
        end
    end

    task automatic push_reset_pulse();
        pulse_t p;
        p.width = T_RST_LOW;
        p.gap   = -1;
        pulse_q.push_back(p);
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            pulse_t p;
            p.width = b[i] ? T_W1_LOW : T_W0_LOW;
            p.gap   = (i < 7) ? (T_SLOT + T_REC - p.width) : -1;
            pulse_q.push_back(p);
        end
    endtask

    task automatic do_start(input logic [4:0] addr, input logic [5:0] cnt);
        @(negedge clk);
        start_address = addr;
        byte_count    = cnt;
        start         = 1'b1;
        @(negedge clk);
        start         = 1'b0;
    endtask

    task automatic wait_done(input string name, output bit seen);
        seen = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_done_timeout: done=0 after 3000 cycles, expected done=1", name);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({read_en, read_address, ow_drive_low, busy, done, presence, error} !== 11'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b, expected all zero",
                     {read_en, read_address, ow_drive_low, busy, done, presence, error});
        end
        reset = 1'b0;
        mon_en = 1;
        @(negedge clk);
    endtask

    task automatic test_single_byte();
        bit seen;
        int d0, r0;
        mem[3] = 8'hA5;
        bram_lat = 3;
        slave_present = 1;
        d0 = done_cnt; r0 = rd_cnt;
        push_reset_pulse();
        addr_q.push_back(3);
        push_byte(8'hA5);
        do_start(5'd3, 6'd1);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL single_busy: got %b, expected 1", busy);
        end
        wait_done("single", seen);
        checks++;
        if (presence !== 1'b1 || error !== 1'b0) begin
            failures++;
            $display("FAIL single_status: presence=%b error=%b, expected presence=1 error=0", presence, error);
        end
        checks++;
        if (done_cnt - d0 !== 1 || rd_cnt - r0 !== 1) begin
            failures++;
            $display("FAIL single_counts: done=%0d reads=%0d, expected 1 and 1", done_cnt - d0, rd_cnt - r0);
        end
        checks++;
        if (pulse_q.size() != 0 || addr_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_leftover: pulses=%0d addrs=%0d busy=%b, expected 0 0 0",
                     pulse_q.size(), addr_q.size(), busy);
        end
    endtask

    task automatic test_no_presence();
        bit seen;
        int r0;
        slave_present = 0;
        r0 = rd_cnt;
        push_reset_pulse();
        do_start(5'd3, 6'd1);
        wait_done("nopres", seen);
        repeat (30) @(negedge clk);
        checks++;
        if (error !== 1'b1 || presence !== 1'b0) begin
            failures++;
            $display("FAIL nopres_status: error=%b presence=%b, expected error=1 presence=0", error, presence);
        end
        checks++;
        if (rd_cnt != r0 || pulse_q.size() != 0) begin
            failures++;
            $display("FAIL nopres_activity: reads=%0d pulses_left=%0d, expected 0 0", rd_cnt - r0, pulse_q.size());
        end
        slave_present = 1;
    endtask

    task automatic test_wrap();
        bit seen;
        mem[31] = 8'hFF;
        mem[0]  = 8'h00;
        bram_lat = 4;
        push_reset_pulse();
        addr_q.push_back(31);
        push_byte(8'hFF);
        addr_q.push_back(0);
        push_byte(8'h00);
        do_start(5'd31, 6'd2);
        wait_done("wrap", seen);
        checks++;
        if (pulse_q.size() != 0 || addr_q.size() != 0 || error !== 1'b0) begin
            failures++;
            $display("FAIL wrap_leftover: pulses=%0d addrs=%0d error=%b, expected 0 0 0",
                     pulse_q.size(), addr_q.size(), error);
        end
        bram_lat = 2;
    endtask

    task automatic test_timeout();
        bit seen;
        bram_noresp = 1;
        push_reset_pulse();
        addr_q.push_back(7);
        do_start(5'd7, 6'd3);
        wait_done("timeout", seen);
        checks++;
        if (last_re_run !== RD_TIMEOUT) begin
            failures++;
            $display("FAIL timeout_read_en_len: got %0d, expected %0d", last_re_run, RD_TIMEOUT);
        end
        checks++;
        if (error !== 1'b1 || ow_drive_low !== 1'b0 || read_en !== 1'b0) begin
            failures++;
            $display("FAIL timeout_status: error=%b drive=%b read_en=%b, expected 1 0 0", error, ow_drive_low, read_en);
        end
        checks++;
        if (pulse_q.size() != 0 || addr_q.size() != 0) begin
            failures++;
            $display("FAIL timeout_leftover: pulses=%0d addrs=%0d, expected 0 0", pulse_q.size(), addr_q.size());
        end
        bram_noresp = 0;
    endtask

    task automatic test_reset_mid_slot();
        bit seen;
        int p0;
        mem[5] = 8'h00;
        p0 = pulse_starts;
        push_reset_pulse();
        addr_q.push_back(5);
        push_byte(8'h00);
        do_start(5'd5, 6'd1);
        seen = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (pulse_starts - p0 >= 2) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL midreset_no_slot: slots=%0d, expected 2", pulse_starts - p0);
        end
        @(negedge clk);
        mon_en = 0;
        reset  = 1'b1;
        @(negedge clk);
        checks++;
        if ({read_en, read_address, ow_drive_low, busy, done, presence, error} !== 11'b0) begin
            failures++;
            $display("FAIL midreset_outputs: got %b, expected all zero",
                     {read_en, read_address, ow_drive_low, busy, done, presence, error});
        end
        reset = 1'b0;
        pulse_q.delete();
        addr_q.delete();
        prev_drv = 0; prev_re = 0; exp_gap = -1; re_run = 0;
        @(negedge clk);
        mon_en = 1;
        test_single_byte();
    endtask

    task automatic test_zero_and_busy();
        bit seen;
        int d0;
        d0 = done_cnt;
        do_start(5'd9, 6'd0);
        // do_start returns one negedge after the accepting edge
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_done: done=%b busy=%b, expected done=1 busy=0", done, busy);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0 || pulse_starts < 0) begin
            failures++;
            $display("FAIL zero_after: dones=%0d busy=%b, expected 1 0", done_cnt - d0, busy);
        end

        d0 = done_cnt;
        mem[3] = 8'hA5;
        push_reset_pulse();
        addr_q.push_back(3);
        push_byte(8'hA5);
        do_start(5'd3, 6'd1);
        repeat (30) @(negedge clk);
        do_start(5'd31, 6'd2);
        wait_done("busy", seen);
        repeat (40) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_ignored_dones: dones=%0d busy=%b, expected 1 0", done_cnt - d0, busy);
        end
        checks++;
        if (pulse_q.size() != 0 || addr_q.size() != 0) begin
            failures++;
            $display("FAIL busy_leftover: pulses=%0d addrs=%0d, expected 0 0", pulse_q.size(), addr_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7);
        test_reset();
        test_single_byte();
        test_no_presence();
        test_wrap();
        test_timeout();
        test_reset_mid_slot();
        test_zero_and_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
